pc_seq: RTL and testbench

- Parametrised successor to the picoMIPS program counter for the affine-transformation core.
- Adds the following to plain increment:
  - signed relative branch
  - absolute branch
  - end-of-program wrap
  - optional return-address stack for CALL/RET
- Sits between the decoder, which drives pc_op and branch_addr, and program memory, which is addressed by PCout.
- Single clock domain, no handshakes. A new PC value appears one cycle after the op.

---
 rtl/pc_pkg.sv | 17 +
 rtl/ret_stack.sv | 58 +++++
 rtl/pc_seq.sv | 139 +++++++++++++
 tb/tb_pc_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the pc_seq program counter.
// Holds the pc_op_t operation encoding and its width.
package pc_pkg;

    localparam int OP_W = 3;

    // Encodings 6 and 7 are unassigned; the sequencer treats them as hold.
    typedef enum logic [OP_W-1:0] {
        OpHold = 3'd0,
        OpIncr = 3'd1,
        OpRel  = 3'd2,
        OpAbs  = 3'd3,
        OpCall = 3'd4,
        OpRet  = 3'd5
    } pc_op_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for pc_seq: StackDepth entries of Psize bits.
// Push takes priority over pop; push when full and pop when empty are ignored.
// Synchronous active-high reset clears the pointer only; contents are don't-care.
module ret_stack #(
    parameter int unsigned Psize      = 4,
    parameter int unsigned StackDepth = 4,
    localparam int unsigned DW        = $clog2(StackDepth + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Psize-1:0] i_data,
    output logic [Psize-1:0] o_top,
    output logic             o_full,
    output logic             o_empty,
    output logic [DW-1:0]    o_depth
);

    localparam int unsigned   IW      = (StackDepth > 1) ? $clog2(StackDepth) : 1;
    localparam logic [DW-1:0] FullCnt = DW'(StackDepth);

    logic [Psize-1:0] r_mem [StackDepth];
    logic [DW-1:0]    r_ptr;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_ptr == FullCnt);
    assign o_empty   = (r_ptr == '0);
    assign o_depth   = r_ptr;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !i_push && !o_empty;
    assign w_wr_idx  = IW'(r_ptr);
    // r_ptr points one past the top; the wrapped value at empty is never used.
    assign w_top_idx = IW'(r_ptr - DW'(1));
    assign o_top     = r_mem[w_top_idx];

    // Stack pointer: counts valid entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + DW'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - DW'(1);
        end
    end

    // Entry storage, written on push only.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program counter sequencer for the affine-transformation core.
// Increment with end-of-program wrap, relative and absolute branches, and
// CALL/RET through a return-address stack when PC_CALL_STACK_EN is defined.
// Without PC_CALL_STACK_EN: CALL acts as ABS, RET as HOLD, stack outputs tie to 0.
module pc_seq
    import pc_pkg::*;
#(
    parameter int unsigned Psize      = 4,
    parameter int unsigned LastAddr   = 2**Psize - 1,
    parameter int unsigned StackDepth = 4,
    localparam int unsigned DW        = $clog2(StackDepth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic [OP_W-1:0]  pc_op,
    input  logic [Psize-1:0] branch_addr,
    output logic [Psize-1:0] PCout,
    output logic             pc_wrap,
    output logic [DW-1:0]    stk_depth,
    output logic             stk_err
);

    localparam logic [Psize-1:0] LastPc = Psize'(LastAddr);

    logic [Psize-1:0] r_pc;
    logic             r_wrap;
    logic [Psize-1:0] w_pc_d;
    logic             w_wrap_d;
    logic [Psize-1:0] w_pc_inc;

`ifdef PC_CALL_STACK_EN
    logic             r_err;
    logic             w_err_d;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [Psize-1:0] w_top;
    logic [DW-1:0]    w_depth;

    ret_stack #(
        .Psize      (Psize),
        .StackDepth (StackDepth)
    ) u_ret_stack (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_depth (w_depth)
    );

    assign stk_depth = w_depth;
    assign stk_err   = r_err;
`else
    assign stk_depth = '0;
    assign stk_err   = 1'b0;
`endif

    assign w_pc_inc = r_pc + Psize'(1);
    assign PCout    = r_pc;
    assign pc_wrap  = r_wrap;

    // Next-state decode; a stall freezes everything and suppresses the wrap pulse.
    always_comb begin
        w_pc_d   = r_pc;
        w_wrap_d = 1'b0;
`ifdef PC_CALL_STACK_EN
        w_err_d  = r_err;
        w_push   = 1'b0;
        w_pop    = 1'b0;
`endif
        if (pc_en) begin
            case (pc_op)
                OpIncr: begin
                    if (r_pc == LastPc) begin
                        w_pc_d   = '0;
                        w_wrap_d = 1'b1;
                    end else begin
                        // Above LastAddr this is a plain modulo-2**Psize increment.
                        w_pc_d = w_pc_inc;
                    end
                end
                // Two's-complement add gives the signed offset modulo 2**Psize.
                OpRel:  w_pc_d = r_pc + branch_addr;
                OpAbs:  w_pc_d = branch_addr;
`ifdef PC_CALL_STACK_EN
                OpCall: begin
                    if (w_full) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_pc_d = branch_addr;
                    end
                end
                OpRet: begin
                    if (w_empty) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_pop  = 1'b1;
                        w_pc_d = w_top;
                    end
                end
`else
                OpCall: w_pc_d = branch_addr;
                OpRet:  w_pc_d = r_pc;
`endif
                default: w_pc_d = r_pc;
            endcase
        end
    end

    // PC and wrap-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_pc   <= w_pc_d;
            r_wrap <= w_wrap_d;
        end
    end

`ifdef PC_CALL_STACK_EN
    // Sticky stack error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq (Psize=4, LastAddr=9, StackDepth=2).
// Expected values are hand-computed; stack-dependent ones follow PC_CALL_STACK_EN.
module tb_pc_seq;
    import pc_pkg::*;

`ifdef PC_CALL_STACK_EN
    localparam bit StkOn = 1'b1;
`else
    localparam bit StkOn = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] pc;
        logic       wrap;
        logic [1:0] depth;
        logic       err;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_en;
    logic [2:0] pc_op;
    logic [3:0] branch_addr;
    logic [3:0] PCout;
    logic       pc_wrap;
    logic [1:0] stk_depth;
    logic       stk_err;

    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    exp_t  exp_q [$];
    string name_q [$];
    exp_t  e;
    string nm;

    pc_seq #(
        .Psize      (4),
        .LastAddr   (9),
        .StackDepth (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .pc_op       (pc_op),
        .branch_addr (branch_addr),
        .PCout       (PCout),
        .pc_wrap     (pc_wrap),
        .stk_depth   (stk_depth),
        .stk_err     (stk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation that falls due in this cycle and compare.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total = total + 1;
            if (e.due != cyc) begin
                bad = bad + 1;
                $display("FAIL %s: checked late at cycle %0d, required cycle %0d", nm, cyc, e.due);
            end else if ({PCout, pc_wrap, stk_depth, stk_err} !==
                         {e.pc, e.wrap, e.depth, e.err}) begin
                bad = bad + 1;
                $display("FAIL %s: got pc=%0d wrap=%0b depth=%0d err=%0b, required pc=%0d wrap=%0b depth=%0d err=%0b",
                         nm, PCout, pc_wrap, stk_depth, stk_err, e.pc, e.wrap, e.depth, e.err);
            end
        end
    end

    // Apply one op for one cycle and queue the state expected after the edge.
    task automatic step(input logic r, input logic en, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] epc, input logic ew,
                        input logic [1:0] ed, input logic ee, input string n);
        exp_t x;
        rst         = r;
        pc_en       = en;
        pc_op       = op;
        branch_addr = a;
        x.pc    = epc;
        x.wrap  = ew;
        x.depth = ed;
        x.err   = ee;
        x.due   = cyc + 1;
        exp_q.push_back(x);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; pc_en = 1'b0; pc_op = 3'd0; branch_addr = 4'd0;
        @(posedge clk);
        #1;
        // Reset and increment
        step(1, 1, OpIncr, 0, 0, 0, 0, 0, "reset1");
        step(1, 0, OpAbs,  7, 0, 0, 0, 0, "reset2");
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, OpIncr, 0, 4'(i), 0, 0, 0, $sformatf("incr%0d", i));
        end
        // Wrap at LastAddr=9
        step(0, 1, OpAbs,  9, 9, 0, 0, 0, "abs9");
        step(0, 1, OpIncr, 0, 0, 1, 0, 0, "wrap_pulse");
        step(0, 1, OpHold, 0, 0, 0, 0, 0, "wrap_one_cycle");
        step(0, 1, OpAbs,  9, 9, 0, 0, 0, "abs9b");
        step(0, 1, OpRel,  1, 10, 0, 0, 0, "rel_past_last");
        step(0, 1, OpIncr, 0, 11, 0, 0, 0, "incr_above_last");
        step(0, 1, OpAbs, 15, 15, 0, 0, 0, "abs15");
        step(0, 1, OpIncr, 0, 0, 0, 0, 0, "natural_wrap");
        // Relative branches
        step(0, 1, OpAbs,  6, 6, 0, 0, 0, "abs6");
        step(0, 1, OpRel,  4'b1110, 4, 0, 0, 0, "rel_minus2");
        step(0, 1, OpAbs, 14, 14, 0, 0, 0, "abs14");
        step(0, 1, OpRel,  3, 1, 0, 0, 0, "rel_mod16");
        step(0, 1, 3'd7,   5, 1, 0, 0, 0, "op7_hold");
        // Stall and priority
        step(0, 1, OpAbs,  9, 9, 0, 0, 0, "abs9c");
        step(0, 0, OpIncr, 0, 9, 0, 0, 0, "stall_incr");
        step(0, 1, OpIncr, 0, 0, 1, 0, 0, "wrap_after_stall");
        step(0, 0, OpIncr, 0, 0, 0, 0, 0, "stall_kills_pulse");
        step(0, 1, OpAbs,  3, 3, 0, 0, 0, "abs3");
        step(0, 0, OpAbs, 12, 3, 0, 0, 0, "stall_abs");
        step(0, 1, OpAbs, 12, 12, 0, 0, 0, "unstall_abs");
        step(1, 1, OpCall, 5, 0, 0, 0, 0, "rst_over_call");
        // Call/return
        step(0, 1, OpAbs,  2, 2, 0, 0, 0, "abs2");
        step(0, 1, OpCall, 8, 8, 0, StkOn ? 2'd1 : 2'd0, 0, "call8");
        step(0, 1, OpCall, 12, 12, 0, StkOn ? 2'd2 : 2'd0, 0, "call12");
        step(0, 0, OpCall, 4, 12, 0, StkOn ? 2'd2 : 2'd0, 0, "stall_call");
        step(0, 1, OpCall, 5, StkOn ? 4'd12 : 4'd5, 0, StkOn ? 2'd2 : 2'd0, StkOn,
             "call_full");
        step(0, 1, OpRet, 0, StkOn ? 4'd9 : 4'd5, 0, StkOn ? 2'd1 : 2'd0, StkOn, "ret1");
        step(0, 1, OpRet, 0, StkOn ? 4'd3 : 4'd5, 0, 0, StkOn, "ret2");
        step(0, 1, OpRet, 0, StkOn ? 4'd3 : 4'd5, 0, 0, StkOn, "ret_empty");
        step(0, 1, OpAbs, 1, 1, 0, 0, StkOn, "abs1_err_sticky");
        step(0, 1, OpCall, 7, 7, 0, StkOn ? 2'd1 : 2'd0, StkOn, "call7");
        step(0, 1, OpRet, 0, StkOn ? 4'd2 : 4'd7, 0, 0, StkOn, "ret_after_call7");
        step(0, 1, OpCall, 7, 7, 0, StkOn ? 2'd1 : 2'd0, StkOn, "call7b");
        step(1, 1, OpRet, 0, 0, 0, 0, 0, "rst_over_ret");
        step(0, 1, OpRet, 0, 0, 0, 0, StkOn, "ret_after_rst");
        step(1, 1, OpHold, 0, 0, 0, 0, 0, "final_rst");
        rst = 1'b0; pc_en = 1'b0; pc_op = 3'd0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
